// File: rtl/gry_ptr_rcvr.sv
// ============================================================================
// gry_ptr_rcvr
// ----------------------------------------------------------------------------
// Consumer-side receiver for a gray-coded pointer generated in another clock
// domain. The incoming gray count is synchronised into clk, decoded to
// binary and checked so that each new sample differs from the previous one
// in at most one bit. A local read pointer is kept beside it, and the block
// reports the fill level, an empty flag and a one-cycle advance pulse.
//
// Parameters
//   WIDTH        pointer width in bits (>= 2)
//   SYNC_STAGES  synchroniser depth on gry_cnt_in (>= 2)
//
// Ports
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   gry_cnt_in   remote gray count, asynchronous to clk
//   rd_en        consume one entry (local read pointer +1)
//   valid        outputs are meaningful (state RUN)
//   bin_cnt      decoded binary remote count
//   rd_ptr       local read pointer (binary)
//   fill_lvl     bin_cnt - rd_ptr, modulo 2^WIDTH
//   empty        fill_lvl == 0
//   adv          one-cycle pulse: bin_cnt updated this cycle
//   gry_err      sticky: illegal gray transition detected
// ============================================================================
module gry_ptr_rcvr #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gry_cnt_in,
    input  logic             rd_en,
    output logic             valid,
    output logic [WIDTH-1:0] bin_cnt,
    output logic [WIDTH-1:0] rd_ptr,
    output logic [WIDTH-1:0] fill_lvl,
    output logic             empty,
    output logic             adv,
    output logic             gry_err
);

    // The INIT counter runs from 0 up to SYNC_STAGES, which takes
    // SYNC_STAGES+1 clocks after reset is released.
    localparam int              CNT_W     = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] g_prev_reg,   g_prev_next;
    logic [WIDTH-1:0] bin_cnt_reg,  bin_cnt_next;
    logic [WIDTH-1:0] rd_ptr_reg,   rd_ptr_next;
    logic             adv_reg,      adv_next;
    logic             gry_err_reg,  gry_err_next;
    logic             valid_reg,    valid_next;
    logic [CNT_W-1:0] init_cnt_reg, init_cnt_next;
    state_t           state_reg,    state_next;

    // ------------------------------------------------------------------
    // Synchroniser chain. Only stage 0 samples the asynchronous input;
    // later stages give a metastable first stage time to resolve.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= gry_cnt_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    logic [WIDTH-1:0] g_s;
    assign g_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Gray -> binary decode. Bit i of the binary value is the XOR of all
    // gray bits from the MSB down to i; writing it as a per-bit reduction
    // avoids a self-referencing vector.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] dec_bin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign dec_bin[gi] = ^g_s[WIDTH-1:gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transition classification between consecutive synchronised samples.
    // A non-zero vector with exactly one bit set satisfies d & (d-1) == 0.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] diff;
    logic             diff_none;
    logic             diff_one;
    logic             diff_multi;

    assign diff       = g_s ^ g_prev_reg;
    assign diff_none  = (diff == '0);
    assign diff_one   = !diff_none && ((diff & (diff - WIDTH'(1))) == '0);
    assign diff_multi = !diff_none && !diff_one;

    // ------------------------------------------------------------------
    // Read-side status, combinational from the registered pointers.
    // Unsigned subtraction wraps naturally modulo 2^WIDTH.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fill_int;
    logic             empty_int;

    assign fill_int  = bin_cnt_reg - rd_ptr_reg;
    assign empty_int = (fill_int == '0);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        g_prev_next   = g_prev_reg;
        bin_cnt_next  = bin_cnt_reg;
        rd_ptr_next   = rd_ptr_reg;
        gry_err_next  = gry_err_reg;
        adv_next      = 1'b0;

        case (state_reg)
            ST_INIT: begin
                // Follow whatever the synchroniser delivers without checking:
                // the chain still holds its reset value or a partly loaded
                // sample, so any jump here is an artefact of start-up.
                g_prev_next  = g_s;
                bin_cnt_next = dec_bin;
                if (init_cnt_reg == INIT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    init_cnt_next = init_cnt_reg + CNT_W'(1);
                end
            end

            ST_RUN: begin
                g_prev_next = g_s;
                if (diff_multi) begin
                    // bin_cnt keeps its last good value.
                    gry_err_next = 1'b1;
                    state_next   = ST_ERR;
                end else if (diff_one) begin
                    bin_cnt_next = dec_bin;
                    adv_next     = 1'b1;
                end
                // Reads are judged against the current (pre-edge) fill
                // level, so a read and an advance in the same cycle both
                // take effect and fill_lvl stays where it was.
                if (rd_en && !empty_int) begin
                    rd_ptr_next = rd_ptr_reg + WIDTH'(1);
                end
            end

            ST_ERR: begin
                // Everything frozen; only rst_n leaves this state.
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase

        valid_next = (state_next == ST_RUN);
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            g_prev_reg   <= '0;
            bin_cnt_reg  <= '0;
            rd_ptr_reg   <= '0;
            adv_reg      <= 1'b0;
            gry_err_reg  <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            g_prev_reg   <= g_prev_next;
            bin_cnt_reg  <= bin_cnt_next;
            rd_ptr_reg   <= rd_ptr_next;
            adv_reg      <= adv_next;
            gry_err_reg  <= gry_err_next;
            valid_reg    <= valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid    = valid_reg;
    assign bin_cnt  = bin_cnt_reg;
    assign rd_ptr   = rd_ptr_reg;
    assign fill_lvl = fill_int;
    assign empty    = empty_int;
    assign adv      = adv_reg;
    assign gry_err  = gry_err_reg;

endmodule

// File: tb/tb_gry_ptr_rcvr.sv
// ============================================================================
// tb_gry_ptr_rcvr
// Directed bench for gry_ptr_rcvr with WIDTH=8, SYNC_STAGES=2. Inputs are
// driven 1 ns after the rising edge, and outputs are sampled at that same
// point before new stimulus is applied.
// ============================================================================
module tb_gry_ptr_rcvr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gry_cnt_in = 8'h00;
    logic       rd_en = 1'b0;
    logic       valid;
    logic [7:0] bin_cnt;
    logic [7:0] rd_ptr;
    logic [7:0] fill_lvl;
    logic       empty;
    logic       adv;
    logic       gry_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    gry_ptr_rcvr #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gry_cnt_in (gry_cnt_in),
        .rd_en      (rd_en),
        .valid      (valid),
        .bin_cnt    (bin_cnt),
        .rd_ptr     (rd_ptr),
        .fill_lvl   (fill_lvl),
        .empty      (empty),
        .adv        (adv),
        .gry_err    (gry_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; gry_cnt_in = 8'h00; rd_en = 1'b0;
        repeat (3) tick();
        total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
        total_cnt++; if (bin_cnt !== 8'd0) $display("FAIL reset_bin_cnt: got %0d want 0", bin_cnt); else pass_cnt++;
        total_cnt++; if (rd_ptr !== 8'd0) $display("FAIL reset_rd_ptr: got %0d want 0", rd_ptr); else pass_cnt++;
        total_cnt++; if (fill_lvl !== 8'd0) $display("FAIL reset_fill: got %0d want 0", fill_lvl); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if ({adv, gry_err} !== 2'b00) $display("FAIL reset_adv_err: got %b want 00", {adv, gry_err}); else pass_cnt++;
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total_cnt++;
            if (valid !== (k == 3)) $display("FAIL init_valid_clk%0d: got %b want %b", k, valid, (k == 3));
            else pass_cnt++;
        end
        $display("test_reset done: valid=%b bin_cnt=%0d", valid, bin_cnt);
    endtask

    // ------------------------------------------------------------------
    task automatic test_step();
        logic [7:0] seq [5];
        int adv_seen;
        seq = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
        adv_seen = 0;
        for (int i = 0; i < 5; i++) begin
            gry_cnt_in = seq[i];
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (adv === 1'b1) adv_seen++;
                if (k == 2) begin
                    total_cnt++;
                    if (bin_cnt !== 8'(i)) $display("FAIL step%0d_early: bin_cnt got %0d want %0d", i, bin_cnt, i);
                    else pass_cnt++;
                end
                if (k == 3) begin
                    total_cnt++;
                    if (bin_cnt !== 8'(i + 1) || adv !== 1'b1)
                        $display("FAIL step%0d_latency: bin_cnt/adv got %0d/%b want %0d/1", i, bin_cnt, adv, i + 1);
                    else pass_cnt++;
                end
            end
            $display("step gray=%h bin_cnt=%0d fill_lvl=%0d", seq[i], bin_cnt, fill_lvl);
        end
        total_cnt++; if (adv_seen != 5) $display("FAIL step_adv_count: got %0d want 5", adv_seen); else pass_cnt++;
        total_cnt++; if (fill_lvl !== 8'd5) $display("FAIL step_fill: got %0d want 5", fill_lvl); else pass_cnt++;
        total_cnt++; if (empty !== 1'b0) $display("FAIL step_empty: got %b want 0", empty); else pass_cnt++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_read();
        rd_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total_cnt++;
            if (rd_ptr !== 8'((k < 5) ? k : 5)) $display("FAIL read_clk%0d: rd_ptr got %0d want %0d", k, rd_ptr, (k < 5) ? k : 5);
            else pass_cnt++;
        end
        rd_en = 1'b0;
        total_cnt++; if (fill_lvl !== 8'd0 || empty !== 1'b1) $display("FAIL read_drain: fill/empty got %0d/%b want 0/1", fill_lvl, empty); else pass_cnt++;
        $display("read done: rd_ptr=%0d fill_lvl=%0d", rd_ptr, fill_lvl);

        // Advance and read landing on the same edge.
        gry_cnt_in = 8'h05;                  // binary 6
        repeat (3) tick();
        total_cnt++; if (fill_lvl !== 8'd1) $display("FAIL coinc_pre: fill got %0d want 1", fill_lvl); else pass_cnt++;
        gry_cnt_in = 8'h04;                  // binary 7
        repeat (2) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++;
        if (adv !== 1'b1 || bin_cnt !== 8'd7 || rd_ptr !== 8'd6 || fill_lvl !== 8'd1)
            $display("FAIL coinc: adv/bin/rd/fill got %b/%0d/%0d/%0d want 1/7/6/1", adv, bin_cnt, rd_ptr, fill_lvl);
        else pass_cnt++;
        $display("coincident adv+rd: bin_cnt=%0d rd_ptr=%0d fill_lvl=%0d", bin_cnt, rd_ptr, fill_lvl);
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        logic [7:0] gseq [4];
        logic [7:0] bseq [4];
        gseq = '{8'h81, 8'h80, 8'h00, 8'h01};
        bseq = '{8'd254, 8'd255, 8'd0, 8'd1};
        rd_en = 1'b1;
        for (int b = 8; b <= 253; b++) begin
            gry_cnt_in = to_gray(8'(b));
            repeat (2) tick();
        end
        repeat (6) tick();
        rd_en = 1'b0;
        total_cnt++;
        if (rd_ptr !== 8'd253 || bin_cnt !== 8'd253 || empty !== 1'b1 || gry_err !== 1'b0)
            $display("FAIL align: rd/bin/empty/err got %0d/%0d/%b/%b want 253/253/1/0", rd_ptr, bin_cnt, empty, gry_err);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            gry_cnt_in = gseq[i];
            repeat (3) tick();
            total_cnt++;
            if (bin_cnt !== bseq[i] || fill_lvl !== 8'(i + 1) || gry_err !== 1'b0)
                $display("FAIL wrap%0d: bin/fill/err got %0d/%0d/%b want %0d/%0d/0", i, bin_cnt, fill_lvl, gry_err, bseq[i], i + 1);
            else pass_cnt++;
            $display("wrap gray=%h bin_cnt=%0d fill_lvl=%0d", gseq[i], bin_cnt, fill_lvl);
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_err();
        int adv_seen;
        adv_seen = 0;
        gry_cnt_in = 8'h07;                  // two bits differ from 0x01
        repeat (3) tick();
        total_cnt++;
        if (gry_err !== 1'b1 || valid !== 1'b0 || bin_cnt !== 8'd1 || adv !== 1'b0)
            $display("FAIL err_detect: err/valid/bin/adv got %b/%b/%0d/%b want 1/0/1/0", gry_err, valid, bin_cnt, adv);
        else pass_cnt++;
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        total_cnt++;
        if (rd_ptr !== 8'd253 || fill_lvl !== 8'd4)
            $display("FAIL err_rd_ignored: rd/fill got %0d/%0d want 253/4", rd_ptr, fill_lvl);
        else pass_cnt++;
        gry_cnt_in = 8'h06;                  // legal step, must not recover
        repeat (4) begin
            tick();
            if (adv === 1'b1) adv_seen++;
        end
        total_cnt++;
        if (gry_err !== 1'b1 || valid !== 1'b0 || bin_cnt !== 8'd1 || adv_seen != 0)
            $display("FAIL err_sticky: err/valid/bin/advs got %b/%b/%0d/%0d want 1/0/1/0", gry_err, valid, bin_cnt, adv_seen);
        else pass_cnt++;
        $display("error state: gry_err=%b valid=%b bin_cnt=%0d", gry_err, valid, bin_cnt);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (gry_err !== 1'b0 || valid !== 1'b0) $display("FAIL err_clear: err/valid got %b/%b want 0/0", gry_err, valid);
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (valid !== 1'b1 || bin_cnt !== 8'd4 || rd_ptr !== 8'd0 || fill_lvl !== 8'd4 || gry_err !== 1'b0)
            $display("FAIL err_restart: valid/bin/rd/fill/err got %b/%0d/%0d/%0d/%b want 1/4/0/4/0", valid, bin_cnt, rd_ptr, fill_lvl, gry_err);
        else pass_cnt++;
        $display("after reset pulse: bin_cnt=%0d fill_lvl=%0d", bin_cnt, fill_lvl);
    endtask

    // ------------------------------------------------------------------
    task automatic test_midreset();
        int adv_seen;
        int err_seen;
        adv_seen = 0;
        err_seen = 0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++; if (fill_lvl !== 8'd3 || rd_ptr !== 8'd1) $display("FAIL mid_pre: fill/rd got %0d/%0d want 3/1", fill_lvl, rd_ptr); else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bin_cnt !== 8'd0 || rd_ptr !== 8'd0 || fill_lvl !== 8'd0 || empty !== 1'b1 || valid !== 1'b0 || adv !== 1'b0 || gry_err !== 1'b0)
            $display("FAIL mid_async: bin/rd/fill/empty/valid got %0d/%0d/%0d/%b/%b want 0/0/0/1/0", bin_cnt, rd_ptr, fill_lvl, empty, valid);
        else pass_cnt++;
        gry_cnt_in = 8'h0D;                  // binary 9
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (adv === 1'b1) adv_seen++;
            if (gry_err === 1'b1) err_seen++;
            total_cnt++;
            if (valid !== (k == 3)) $display("FAIL mid_valid_clk%0d: got %b want %b", k, valid, (k == 3));
            else pass_cnt++;
        end
        repeat (2) begin
            tick();
            if (adv === 1'b1) adv_seen++;
            if (gry_err === 1'b1) err_seen++;
        end
        total_cnt++;
        if (bin_cnt !== 8'd9 || fill_lvl !== 8'd9 || adv_seen != 0 || err_seen != 0)
            $display("FAIL mid_pickup: bin/fill/advs/errs got %0d/%0d/%0d/%0d want 9/9/0/0", bin_cnt, fill_lvl, adv_seen, err_seen);
        else pass_cnt++;
        $display("mid-stream reset: bin_cnt=%0d fill_lvl=%0d valid=%b", bin_cnt, fill_lvl, valid);
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_step();
        test_read();
        test_wrap();
        test_err();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
